leading_count_pipe: RTL and testbench

Parametrised, 2-stage pipelined count-leading-zeros/ones unit for the pipelined CPU's execute path. It implements both MIPS CLZ and CLO with a valid/ready handshake, backpressure, flush, and a destination tag carried alongside each result. It is the successor to the single-cycle 32-bit combinational counter. It sustains one operation per cycle and lets the CPU register the count off the critical ALU path.

---
 rtl/leading_count_pipe_if.sv | 39 +++
 rtl/leading_count_pipe.sv | 133 +++++++++++++
 tb/tb_leading_count_pipe.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/leading_count_pipe_if.sv
// rtl/leading_count_pipe_if.sv - operand/result handshake bundle for leading_count_pipe
//
// Carries the operand stream (in_*) and the result stream (out_*).
//   slave  : the counting unit (consumes operands, produces results)
//   master : the execute stage driving operands and accepting results
//
//   in_valid / in_ready   operand handshake
//   in_data  [WIDTH]      operand
//   in_mode               0 = count leading zeros, 1 = count leading ones
//   in_tag   [TAG_W]      opaque tag returned with the result
//   out_valid / out_ready result handshake
//   out_count[CW]         leading-bit count, 0..WIDTH
//   out_tag  [TAG_W]      tag of the result
interface leading_count_pipe_if #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
) ();
    localparam int CW = $clog2(WIDTH) + 1;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_mode;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [CW-1:0]    out_count;
    logic [TAG_W-1:0] out_tag;

    modport slave (
        input  in_valid, in_data, in_mode, in_tag, out_ready,
        output in_ready, out_valid, out_count, out_tag
    );

    modport master (
        output in_valid, in_data, in_mode, in_tag, out_ready,
        input  in_ready, out_valid, out_count, out_tag
    );
endinterface

// File: rtl/leading_count_pipe.sv
// rtl/leading_count_pipe.sv - 2-stage pipelined count-leading-zeros/ones unit
//
// Stage 1 inverts the operand for CLO, splits it into WIDTH/CHUNK chunks
// (chunk 0 holds the MSBs) and registers a per-chunk all-zero flag and
// per-chunk leading-zero count. Stage 2 picks the first non-empty chunk and
// registers the final count. One result per cycle, two operations in flight.
//
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   flush      synchronous kill of both pipeline stages
//   port       leading_count_pipe_if.slave (operand and result streams)
module leading_count_pipe #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8,
    parameter int TAG_W = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    leading_count_pipe_if.slave  port
);
    localparam int N  = WIDTH / CHUNK;
    localparam int CW = $clog2(WIDTH) + 1;
    localparam int KW = $clog2(CHUNK) + 1;

    // Leading zeros within one chunk, 0..CHUNK.
    function automatic logic [KW-1:0] chunk_lz(input logic [CHUNK-1:0] c);
        logic [KW-1:0] n;
        logic          hit;
        n   = '0;
        hit = 1'b0;
        for (int i = CHUNK - 1; i >= 0; i--) begin
            if (!hit && !c[i]) begin
                n = n + 1'b1;
            end else begin
                hit = 1'b1;
            end
        end
        return n;
    endfunction

    // Pipeline state
    logic             s1_valid;
    logic [N-1:0]     s1_all;
    logic [KW-1:0]    s1_cnt [N];
    logic [TAG_W-1:0] s1_tag;
    logic             out_valid_q;
    logic [CW-1:0]    out_count_q;
    logic [TAG_W-1:0] out_tag_q;

    // Handshake
    logic adv1;
    logic adv2;
    logic in_xfer;

    assign adv2 = !out_valid_q || port.out_ready;
    assign adv1 = !s1_valid || adv2;
    // rst_n is folded in so the unit never advertises space while held in reset.
    assign port.in_ready  = adv1 && !flush && rst_n;
    assign in_xfer        = port.in_valid && port.in_ready;

    assign port.out_valid = out_valid_q;
    assign port.out_count = out_count_q;
    assign port.out_tag   = out_tag_q;

    // Stage 1 combinational: CLO is CLZ of the inverted operand.
    logic [WIDTH-1:0] opnd;
    logic [N-1:0]     c_all;
    logic [KW-1:0]    c_cnt [N];

    always_comb begin
        opnd  = port.in_mode ? ~port.in_data : port.in_data;
        c_all = '0;
        for (int k = 0; k < N; k++) begin
            c_cnt[k] = '0;
        end
        for (int k = 0; k < N; k++) begin
            c_all[k] = ~|opnd[WIDTH-1-k*CHUNK -: CHUNK];
            c_cnt[k] = chunk_lz(opnd[WIDTH-1-k*CHUNK -: CHUNK]);
        end
    end

    // Stage 2 combinational: scanning from the LSB chunk upward lets the
    // last assignment win, so the lowest-index non-empty chunk decides.
    logic [CW-1:0] s2_count;

    always_comb begin
        s2_count = CW'(WIDTH);
        for (int k = N - 1; k >= 0; k--) begin
            if (!s1_all[k]) begin
                s2_count = CW'(k * CHUNK) + CW'(s1_cnt[k]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_all   <= '0;
            s1_tag   <= '0;
            for (int k = 0; k < N; k++) begin
                s1_cnt[k] <= '0;
            end
            out_valid_q <= 1'b0;
            out_count_q <= '0;
            out_tag_q   <= '0;
        end else if (flush) begin
            // Data registers keep stale contents; only the valid bits matter.
            s1_valid    <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            if (adv1) begin
                s1_valid <= in_xfer;
                if (in_xfer) begin
                    s1_all <= c_all;
                    s1_tag <= port.in_tag;
                    for (int k = 0; k < N; k++) begin
                        s1_cnt[k] <= c_cnt[k];
                    end
                end
            end
            if (adv2) begin
                out_valid_q <= s1_valid;
                // Bubbles leave the previous result in place rather than
                // loading a count computed from stale stage-1 contents.
                if (s1_valid) begin
                    out_count_q <= s2_count;
                    out_tag_q   <= s1_tag;
                end
            end
        end
    end
endmodule

// File: tb/tb_leading_count_pipe.sv
// tb/tb_leading_count_pipe.sv - self-checking bench for leading_count_pipe
module tb_leading_count_pipe;
    localparam int W  = 32;
    localparam int C  = 8;
    localparam int T  = 5;
    localparam int CW = 6;
    localparam int W2 = 64;
    localparam int C2 = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic flush;
    logic flush2;

    leading_count_pipe_if #(.WIDTH(W),  .TAG_W(T)) bus  ();
    leading_count_pipe_if #(.WIDTH(W2), .TAG_W(T)) bus2 ();

    leading_count_pipe #(.WIDTH(W), .CHUNK(C), .TAG_W(T)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .port  (bus.slave)
    );

    leading_count_pipe #(.WIDTH(W2), .CHUNK(C2), .TAG_W(T)) dut64 (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush2),
        .port  (bus2.slave)
    );

    int checks   = 0;
    int failures = 0;
    int n_out    = 0;
    bit last_in_xfer;

    logic [CW-1:0] q_cnt [$];
    logic [T-1:0]  q_tag [$];

    // Reference: scan from the MSB for the first bit that differs from the mode.
    function automatic int ref_count(logic [63:0] d, bit mode, int w);
        for (int i = w - 1; i >= 0; i--) begin
            if (d[i] != mode) return w - 1 - i;
        end
        return w;
    endfunction

    task automatic check(string name, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    // One clock: sample handshakes mid-cycle, update scoreboard, step past the edge.
    task automatic cyc();
        #4;
        last_in_xfer = 1'b0;
        if (!rst_n) begin
            q_cnt.delete();
            q_tag.delete();
        end else begin
            if (bus.out_valid && bus.out_ready) begin
                n_out++;
                if (q_cnt.size() == 0) begin
                    check("out_without_pending_op", bus.out_valid, 0);
                end else begin
                    check("sb_count", bus.out_count, q_cnt.pop_front());
                    check("sb_tag", bus.out_tag, q_tag.pop_front());
                end
            end
            if (flush) begin
                q_cnt.delete();
                q_tag.delete();
            end else if (bus.in_valid && bus.in_ready) begin
                last_in_xfer = 1'b1;
                q_cnt.push_back(6'(ref_count({32'b0, bus.in_data}, bus.in_mode, W)));
                q_tag.push_back(bus.in_tag);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(logic [W-1:0] d, bit m, logic [T-1:0] t);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_mode  = m;
        bus.in_tag   = t;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (last_in_xfer) break;
        end
        check("send_accepted", last_in_xfer, 1);
        bus.in_valid = 1'b0;
    endtask

    logic [31:0] t1_op  [5] = '{32'h0000_0000, 32'h8000_0000, 32'h0001_0000, 32'h0000_0001, 32'h00FF_0000};
    int          t1_exp [5] = '{32, 0, 15, 31, 8};
    logic [31:0] t2_op  [4] = '{32'hFFFF_FFFF, 32'hFFF0_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFE};
    int          t2_exp [4] = '{32, 12, 0, 31};
    logic [63:0] t6_op  [3] = '{64'h0000_0000_0000_8000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0};
    bit          t6_mode[3] = '{1'b0, 1'b1, 1'b0};
    int          t6_exp [3] = '{48, 64, 64};

    initial begin
        int n0;
        int sh;
        logic [31:0] d;
        bit m;

        rst_n = 1'b0;
        flush = 1'b0;
        flush2 = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.in_mode = 1'b0;
        bus.in_tag = '0;
        bus.out_ready = 1'b1;
        bus2.in_valid = 1'b0;
        bus2.in_data = '0;
        bus2.in_mode = 1'b0;
        bus2.in_tag = '0;
        bus2.out_ready = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) cyc();

        // Reset state
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_count", bus.out_count, 0);
        check("rst_out_tag", bus.out_tag, 0);
        rst_n = 1'b1;
        cyc();
        check("idle_in_ready", bus.in_ready, 1);

        // CLZ directed, with latency
        for (int i = 0; i < 5; i++) begin
            send(t1_op[i], 1'b0, 5'(i + 1));
            check("clz_lat_not_yet", bus.out_valid, 0);
            cyc();
            check("clz_valid", bus.out_valid, 1);
            check("clz_count", bus.out_count, t1_exp[i]);
            cyc();
        end

        // CLO directed
        for (int i = 0; i < 4; i++) begin
            send(t2_op[i], 1'b1, 5'(i + 8));
            cyc();
            check("clo_valid", bus.out_valid, 1);
            check("clo_count", bus.out_count, t2_exp[i]);
            cyc();
        end

        // Streaming: 6 back-to-back ops
        n0 = n_out;
        for (int i = 1; i <= 6; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = $urandom;
            bus.in_mode  = 1'($urandom_range(0, 1));
            bus.in_tag   = 5'(i);
            cyc();
            check("stream_accept", last_in_xfer, 1);
            if (i >= 2) check("stream_out_valid", bus.out_valid, 1);
        end
        bus.in_valid = 1'b0;
        cyc();
        check("stream_out_valid_last", bus.out_valid, 1);
        cyc();
        check("stream_out_valid_end", bus.out_valid, 0);
        check("stream_count", n_out - n0, 6);

        // Backpressure
        bus.out_ready = 1'b0;
        send(32'h0000_F000, 1'b0, 5'd10);
        send(32'hFF00_0000, 1'b1, 5'd11);
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h0000_0003;
        bus.in_mode  = 1'b0;
        bus.in_tag   = 5'd12;
        #1;
        check("bp_in_ready_low", bus.in_ready, 0);
        for (int i = 0; i < 4; i++) begin
            cyc();
            check("bp_no_accept", last_in_xfer, 0);
            check("bp_count_hold", bus.out_count, q_cnt[0]);
            check("bp_tag_hold", bus.out_tag, q_tag[0]);
        end
        bus.out_ready = 1'b1;
        n0 = n_out;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (last_in_xfer) bus.in_valid = 1'b0;
            if (q_cnt.size() == 0 && !bus.in_valid) break;
        end
        check("bp_delivered", n_out - n0, 3);
        check("bp_queue_empty", q_cnt.size(), 0);

        // Flush with two ops in flight
        send(32'h0010_0000, 1'b0, 5'd20);
        send(32'h0000_0100, 1'b0, 5'd21);
        flush = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h0400_0000;
        bus.in_mode  = 1'b0;
        bus.in_tag   = 5'd22;
        #1;
        check("flush_in_ready", bus.in_ready, 0);
        cyc();
        check("flush_no_accept", last_in_xfer, 0);
        check("flush_out_valid", bus.out_valid, 0);
        check("flush_s1_valid", dut.s1_valid, 0);
        flush = 1'b0;
        n0 = n_out;
        send(32'h0400_0000, 1'b0, 5'd22);
        cyc();
        check("post_flush_valid", bus.out_valid, 1);
        check("post_flush_tag", bus.out_tag, 22);
        check("post_flush_count", bus.out_count, 5);
        cyc();
        check("post_flush_delivered", n_out - n0, 1);

        // Reset mid-stream
        send(32'h0000_0080, 1'b0, 5'd25);
        send(32'h0000_0000, 1'b1, 5'd26);
        rst_n = 1'b0;
        cyc();
        check("mrst_out_valid", bus.out_valid, 0);
        check("mrst_out_count", bus.out_count, 0);
        check("mrst_out_tag", bus.out_tag, 0);
        check("mrst_in_ready", bus.in_ready, 0);
        check("mrst_s1_valid", dut.s1_valid, 0);
        rst_n = 1'b1;
        cyc();
        cyc();
        check("mrst_stays_empty", bus.out_valid, 0);

        // Randomized traffic with occasional flush
        for (int i = 0; i < 400; i++) begin
            sh = $urandom_range(0, 32);
            d  = (sh == 32) ? 32'h0 : ((32'($urandom) | 32'h8000_0000) >> sh);
            m  = 1'($urandom_range(0, 1));
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.in_data   = m ? ~d : d;
            bus.in_mode   = m;
            bus.in_tag    = 5'($urandom);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            flush         = ($urandom_range(0, 39) == 0);
            cyc();
        end
        flush = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 10; i++) cyc();
        check("rand_drained", q_cnt.size(), 0);
        check("rand_out_idle", bus.out_valid, 0);

        // 64-bit instance, 16-bit chunks
        for (int i = 0; i < 3; i++) begin
            bus2.in_valid = 1'b1;
            bus2.in_data  = t6_op[i];
            bus2.in_mode  = t6_mode[i];
            bus2.in_tag   = 5'(i + 3);
            #3;
            check("w64_in_ready", bus2.in_ready, 1);
            cyc();
            bus2.in_valid = 1'b0;
            cyc();
            check("w64_valid", bus2.out_valid, 1);
            check("w64_count", bus2.out_count, t6_exp[i]);
            check("w64_count_model", bus2.out_count, ref_count(t6_op[i], t6_mode[i], W2));
            check("w64_tag", bus2.out_tag, i + 3);
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
